// File: rtl/hawk_pkg.sv
// Shared HAWK pedestrian-crossing definitions: controller state encodings,
// walk-counter terminal value and datapath widths.
package hawk_pkg;

  localparam int unsigned HAWK_COUNT_W = 4;
  localparam int unsigned HAWK_DWELL_W = 8;

  localparam logic [HAWK_COUNT_W-1:0] HAWK_WALK_DONE = 4'hA;

  // Controller state encodings; S0 is idle, S9 is walk.
  typedef enum logic [3:0] {
    S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,
    S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,
    S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11,
    S12 = 4'd12, S13 = 4'd13
  } hawk_state_e;

endpackage

// File: rtl/hawk_request_timer_if.sv
// Controller <-> request/timer bundle.
//   ped_btn   : raw push-button (board side)
//   clr_count : controller idle (S0) indicator
//   inc_count : controller walk (S9) indicator
//   RL        : controller red-light output
//   YP        : pending pedestrian request
//   NS        : red dwell complete
//   count     : walk counter
//   tick      : prescaled timing pulse
// master = controller/board side, slave = hawk_request_timer.
interface hawk_request_timer_if;
  import hawk_pkg::*;

  logic                    ped_btn;
  logic                    clr_count;
  logic                    inc_count;
  logic                    RL;
  logic                    YP;
  logic                    NS;
  logic [HAWK_COUNT_W-1:0] count;
  logic                    tick;

  modport master (
    output ped_btn, clr_count, inc_count, RL,
    input  YP, NS, count, tick
  );

  modport slave (
    input  ped_btn, clr_count, inc_count, RL,
    output YP, NS, count, tick
  );

endinterface

// File: rtl/hawk_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stable-count
// filter. o_clean follows the synchronized level only after it has differed
// from o_clean for DEBOUNCE_CYCLES consecutive clocks.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw asynchronous button
//   o_clean    : debounced level (registered)
module hawk_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_clean
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_clean;
  logic [CNT_W-1:0] r_cnt;

  // Synchronizer, then count consecutive disagreements before accepting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] != r_clean) begin
        if (r_cnt == CNT_LAST) begin
          r_clean <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/hawk_request_timer.sv
// HAWK front-end: tick prescaler, pedestrian request latch (YP), red dwell
// qualifier (NS) and walk counter (count).
//   clk, rst_n : clock, async active-low reset
//   bus        : hawk_request_timer_if.slave (ped_btn, clr_count, inc_count,
//                RL in; YP, NS, count, tick out, all registered)
// Build option: define HAWK_REQ_DEBOUNCE_EN to insert the debounce filter;
// otherwise the synchronized button drives the edge detector directly.
module hawk_request_timer
  import hawk_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned RED_DWELL       = 3
) (
  input logic           clk,
  input logic           rst_n,
  hawk_request_timer_if.slave bus
);

  localparam int unsigned PRESC_W = 16;
  localparam logic [PRESC_W-1:0]      TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [HAWK_DWELL_W-1:0] DWELL_TGT = HAWK_DWELL_W'(RED_DWELL);
  localparam logic [HAWK_DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [HAWK_COUNT_W-1:0] COUNT_MAX = '1;

  if (TICK_DIV < 1 || TICK_DIV > 65535 || DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > 255 || RED_DWELL < 1 || RED_DWELL > 255) begin : g_param_check
    $error("hawk_request_timer: parameter out of legal range");
  end

  logic                    w_btn_clean;
  logic                    w_yp_set;
  logic                    w_yp_clr;
  logic [PRESC_W-1:0]      r_presc;
  logic                    r_tick;
  logic                    r_clean_d;
  logic                    r_rise;
  logic                    r_clr_d;
  logic                    r_yp;
  logic [HAWK_DWELL_W-1:0] r_dwell;
  logic                    r_ns;
  logic [HAWK_COUNT_W-1:0] r_count;

`ifdef HAWK_REQ_DEBOUNCE_EN
  hawk_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.ped_btn),
    .o_clean (w_btn_clean)
  );
`else
  logic [1:0] r_sync;

  // Bare synchronizer when filtering is not built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], bus.ped_btn};
  end

  assign w_btn_clean = r_sync[1];
`endif

  // Prescaler; tick lands the cycle after the counter hits TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= (r_presc == TICK_LAST);
      if (r_presc == TICK_LAST) r_presc <= '0;
      else                      r_presc <= r_presc + 1'b1;
    end
  end

  // Set on a registered rising edge of the clean button, clear when the
  // controller leaves S0; a coincident set wins so the press is not lost.
  assign w_yp_set = r_rise;
  assign w_yp_clr = r_clr_d & ~bus.clr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean_d <= 1'b0;
      r_rise    <= 1'b0;
      r_clr_d   <= 1'b1;
      r_yp      <= 1'b0;
    end else begin
      r_clean_d <= w_btn_clean;
      r_rise    <= w_btn_clean & ~r_clean_d;
      r_clr_d   <= bus.clr_count;
      r_yp      <= w_yp_set | (r_yp & ~w_yp_clr);
    end
  end

  // Red dwell: count ticks while RL is held, saturating; NS lags the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_ns    <= 1'b0;
    end else if (!bus.RL) begin
      r_dwell <= '0;
      r_ns    <= 1'b0;
    end else begin
      if (r_tick && (r_dwell != DWELL_MAX)) r_dwell <= r_dwell + 1'b1;
      r_ns <= (r_dwell >= DWELL_TGT);
    end
  end

  // Walk counter: clear dominates, ticks advance it while walking, no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.clr_count) begin
      r_count <= '0;
    end else if (bus.inc_count && r_tick && (r_count != COUNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.YP    = r_yp;
  assign bus.NS    = r_ns;
  assign bus.count = r_count;
  assign bus.tick  = r_tick;

endmodule

// File: tb/tb_hawk_request_timer.sv
// Scoreboard bench for hawk_request_timer (TICK_DIV=4, DEBOUNCE_CYCLES=3,
// RED_DWELL=2). Stimulus queues expected values tagged with the cycle they
// must hold; the monitor compares on the falling edge of that cycle.
module tb_hawk_request_timer;
  import hawk_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned DWELL    = 2;
`ifdef HAWK_REQ_DEBOUNCE_EN
  localparam int LAT = 2 + int'(DEB) + 2;
`else
  localparam int LAT = 4;
`endif

  localparam int SIG_YP   = 0;
  localparam int SIG_NS   = 1;
  localparam int SIG_CNT  = 2;
  localparam int SIG_TICK = 3;

  typedef struct {
    int         cyc;
    int         sig;
    int         tag;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   t0    = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tag = 0;

  hawk_request_timer_if bus();

  hawk_request_timer #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .RED_DWELL       (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_tick(int c);
    return (c > t0) && (((c - t0) % int'(TICK_DIV)) == 0);
  endfunction

  function automatic int next_tick(int c);
    int t = c;
    while (!is_tick(t)) t++;
    return t;
  endfunction

  function automatic string sname(int s);
    case (s)
      SIG_YP:  return "YP";
      SIG_NS:  return "NS";
      SIG_CNT: return "count";
      default: return "tick";
    endcase
  endfunction

  function automatic logic [3:0] sample(int s);
    case (s)
      SIG_YP:  return {3'b000, bus.YP};
      SIG_NS:  return {3'b000, bus.NS};
      SIG_CNT: return bus.count;
      default: return {3'b000, bus.tick};
    endcase
  endfunction

  task automatic push_exp(int dc, int sig, logic [3:0] v);
    exp_t e;
    int   i;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.tag = n_tag;
    e.val = v;
    n_tag++;
    i = q.size();
    while (i > 0 && q[i-1].cyc > e.cyc) i--;
    q.insert(i, e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  exp_t       m_e;
  logic [3:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e   = q.pop_front();
      m_act = sample(m_e.sig);
      n_cmp++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        n_bad++;
        $display("FAIL chk%0d %s @cyc %0d (due %0d): got %h expected %h",
                 m_e.tag, sname(m_e.sig), cyc, m_e.cyc, m_act, m_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int m;
    int n;
    int d;
    int t2;
    int guard;

    bus.ped_btn   = 1'b0;
    bus.clr_count = 1'b1;
    bus.inc_count = 1'b0;
    bus.RL        = 1'b0;
    rst_n         = 1'b0;

    // Reset state, then first tick 4 clocks after release.
    @(negedge clk);
    for (int s = 0; s < 4; s++) push_exp(1, s, 4'h0);
    step(1);
    rst_n = 1'b1;
    t0    = cyc;
    for (int i = 1; i <= 5; i++) push_exp(i, SIG_TICK, {3'b000, is_tick(cyc + i)});
    push_exp(5, SIG_YP, 4'h0);
    push_exp(5, SIG_CNT, 4'h0);
    step(6);

`ifdef HAWK_REQ_DEBOUNCE_EN
    // 2-clock glitch is filtered out.
    bus.ped_btn = 1'b1;
    for (int i = 3; i <= 10; i++) push_exp(i, SIG_YP, 4'h0);
    step(2);
    bus.ped_btn = 1'b0;
    step(10);
`else
    // 1-clock pulse reaches YP after 4 clocks.
    bus.ped_btn = 1'b1;
    push_exp(3, SIG_YP, 4'h0);
    push_exp(4, SIG_YP, 4'h1);
    step(1);
    bus.ped_btn = 1'b0;
    step(6);
`endif
    bus.clr_count = 1'b0;
    push_exp(1, SIG_YP, 4'h0);
    step(2);
    bus.clr_count = 1'b1;
    step(2);

    // Sustained press: YP exactly LAT clocks after the rise, then held.
    bus.ped_btn = 1'b1;
    push_exp(LAT - 1, SIG_YP, 4'h0);
    push_exp(LAT, SIG_YP, 4'h1);
    step(10);
    bus.ped_btn = 1'b0;
    step(8);
    push_exp(1, SIG_YP, 4'h1);
    step(1);

    // Controller leaves S0: YP clears next clock.
    bus.clr_count = 1'b0;
    push_exp(1, SIG_YP, 4'h0);
    step(2);
    bus.clr_count = 1'b1;
    step(2);

    // Press landing on the clear edge: set wins and holds through the cycle.
    bus.ped_btn = 1'b1;
    push_exp(LAT - 1, SIG_YP, 4'h0);
    push_exp(LAT, SIG_YP, 4'h1);
    push_exp(LAT + 1, SIG_YP, 4'h1);
    step(LAT - 1);
    bus.clr_count = 1'b0;
    push_exp(3, SIG_YP, 4'h1);
    step(11 - LAT);
    bus.ped_btn = 1'b0;
    step(3);
    push_exp(1, SIG_YP, 4'h1);
    step(1);
    bus.clr_count = 1'b1;
    step(2);
    bus.clr_count = 1'b0;
    push_exp(1, SIG_YP, 4'h0);
    step(2);

    // Dwell: NS one clock after the 2nd tick is consumed; restart from 0.
    for (int r = 0; r < 2; r++) begin
      bus.RL = 1'b1;
      t2 = next_tick(cyc) + int'(TICK_DIV);
      push_exp(1, SIG_NS, 4'h0);
      push_exp(t2 + 1 - cyc, SIG_NS, 4'h0);
      push_exp(t2 + 2 - cyc, SIG_NS, 4'h1);
      d = t2 + 4 - cyc;
      step(d);
      bus.RL = 1'b0;
      push_exp(1, SIG_NS, 4'h0);
      step(3);
    end

    // Walk counter: one step per tick, saturating at F.
    bus.inc_count = 1'b1;
    m = 0;
    repeat (72) begin
      if (is_tick(cyc) && m < 15) m++;
      push_exp(1, SIG_CNT, 4'(m));
      step(1);
    end
    bus.clr_count = 1'b1;
    repeat (6) begin
      push_exp(1, SIG_CNT, 4'h0);
      step(1);
    end
    bus.inc_count = 1'b0;
    step(1);

    // Async reset mid-operation with count=5, YP=1, NS=1.
    bus.clr_count = 1'b0;
    bus.inc_count = 1'b1;
    bus.RL        = 1'b1;
    bus.ped_btn   = 1'b1;
    m = 0;
    n = 0;
    while (m < 5) begin
      if (is_tick(cyc)) m++;
      push_exp(1, SIG_CNT, 4'(m));
      step(1);
      n++;
      if (n == 10) bus.ped_btn = 1'b0;
    end
    bus.inc_count = 1'b0;
    push_exp(1, SIG_CNT, 4'h5);
    push_exp(1, SIG_YP, 4'h1);
    push_exp(1, SIG_NS, 4'h1);
    for (int s = 0; s < 4; s++) push_exp(2, s, 4'h0);
    step(1);
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    bus.clr_count = 1'b1;
    bus.RL        = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) push_exp(1, s, 4'h0);
    step(1);
    rst_n = 1'b1;
    t0    = cyc;
    for (int i = 1; i <= 5; i++) push_exp(i, SIG_TICK, {3'b000, is_tick(cyc + i)});
    push_exp(5, SIG_YP, 4'h0);
    step(8);

    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      step(1);
      guard++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks left unevaluated, required 0", q.size());
      n_bad += q.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
